// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (MAGIC, N, N*4 data bytes, CHK)
// and writes the words into the instruction memory. The CPU core is held in
// reset until a complete frame with a matching XOR checksum has been written.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for MAGIC after reset, other bytes discarded
// S_COUNT | waiting for the word count byte N
// S_DATA  | assembling a 32-bit word from four little-endian bytes
// S_WRITE | one-cycle memory write strobe, no byte accepted
// S_CHECK | waiting for the checksum byte
// S_DONE  | image verified, core released, MAGIC restarts a load
// S_ERR   | frame aborted (checksum, length or timeout), MAGIC restarts
//
// ADDR_W must not exceed 8: the word count byte cannot address more words.

module imem_loader #(
    parameter int          ADDR_W      = 6,
    parameter logic [7:0]  MAGIC       = 8'hA5,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       n_words;
    logic [7:0]       word_idx;
    logic [1:0]       byte_idx;
    logic [7:0]       xor_acc;
    logic [23:0]      asm_reg;
    logic [TMR_W-1:0] tmr;
    logic             xfer;
    logic             timed;
    logic             start;

    assign xfer   = rx_valid && rx_ready;
    assign timed  = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    assign start  = xfer && (rx_data == MAGIC) &&
                    ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign mem_we = (state == S_WRITE);

    // State register.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic; an expired idle timer overrides the normal transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                if (xfer) begin
                    if ({24'd0, rx_data} > 32'(1 << ADDR_W)) state_nxt = S_ERR;
                    else if (rx_data == 8'd0)                state_nxt = S_CHECK;
                    else                                     state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (word_idx + 8'd1 == n_words) state_nxt = S_CHECK;
                else                            state_nxt = S_DATA;
            end
            S_CHECK: begin
                if (xfer) state_nxt = (rx_data == xor_acc) ? S_DONE : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (timed && !xfer && tmr == '0) state_nxt = S_ERR;
    end

    // Status outputs registered from the next state so they change on the
    // edge that enters the corresponding state.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_ready  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            rx_ready  <= (state_nxt != S_WRITE);
            load_done <= (state_nxt == S_DONE);
            load_err  <= (state_nxt == S_ERR);
            cpu_rst_n <= (state_nxt == S_DONE);
        end
    end

    // Inter-byte idle timer: down-counter reloaded on every transfer and
    // whenever the frame is not waiting on the byte stream.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)           tmr <= TMR_RELOAD;
        else if (!timed || xfer)  tmr <= TMR_RELOAD;
        else if (tmr != '0)       tmr <= tmr - 1'b1;
    end

    // Frame datapath: word count, byte/word indices, assembly and checksum.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            n_words  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            xor_acc  <= '0;
            asm_reg  <= '0;
        end else if (start) begin
            word_idx <= '0;
            byte_idx <= '0;
            xor_acc  <= '0;
        end else begin
            if (state == S_COUNT && xfer) n_words <= rx_data;
            if (state == S_DATA && xfer) begin
                asm_reg  <= {rx_data, asm_reg[23:8]};
                xor_acc  <= xor_acc ^ rx_data;
                byte_idx <= byte_idx + 2'd1;
            end
            if (state == S_WRITE) word_idx <= word_idx + 8'd1;
        end
    end

    // Write address/data latched with the 4th byte; held between strobes.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == S_DATA && xfer && byte_idx == 2'd3) begin
            mem_addr  <= word_idx[ADDR_W-1:0];
            mem_wdata <= {rx_data, asm_reg};
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a short inter-byte timeout.

module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst_n;
    logic              load_done;
    logic              load_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] wr_addr [32];
    logic [31:0]       wr_data [32];
    int                wr_cnt = 0;

    imem_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Log every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr[wr_cnt % 32] = mem_addr;
            wr_data[wr_cnt % 32] = mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            ok = rx_ready;
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_byte timeout: byte %02h never accepted", b);
        end
    endtask

    task automatic idle();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes [], input int len);
        for (int i = 0; i < len; i++) send_byte(bytes[i]);
        idle();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rx_ready, mem_we, cpu_rst_n, load_done, load_err} !== 5'b00000)
            $display("FAIL reset_flags: got %b expected 00000",
                     {rx_ready, mem_we, cpu_rst_n, load_done, load_err});
        else n_pass++;
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== 32'h0)
            $display("FAIL reset_mem_bus: addr %0d data %08h expected 0/0", mem_addr, mem_wdata);
        else n_pass++;
        sys_rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rx_ready !== 1'b1) $display("FAIL idle_ready: got %b expected 1", rx_ready);
        else n_pass++;
    endtask

    task automatic test_valid_load();
        int base;
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h93); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        n_checks++;
        if ({mem_we, rx_ready} !== 2'b10 || mem_addr !== 6'd0 || mem_wdata !== 32'h0000_0293)
            $display("FAIL write_latency: we/ready %b addr %0d data %08h expected 10/0/00000293",
                     {mem_we, rx_ready}, mem_addr, mem_wdata);
        else n_pass++;
        send_byte(8'h13); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h81);
        idle();
        n_checks++;
        if (wr_cnt - base !== 2 || wr_addr[base % 32] !== 6'd0 || wr_data[base % 32] !== 32'h293 ||
            wr_addr[(base + 1) % 32] !== 6'd1 || wr_data[(base + 1) % 32] !== 32'h313)
            $display("FAIL valid_writes: count %0d a0 %0d d0 %08h a1 %0d d1 %08h expected 2 0 293 1 313",
                     wr_cnt - base, wr_addr[base % 32], wr_data[base % 32],
                     wr_addr[(base + 1) % 32], wr_data[(base + 1) % 32]);
        else n_pass++;
        n_checks++;
        if ({load_done, cpu_rst_n, load_err} !== 3'b110)
            $display("FAIL valid_status: done/cpu/err %b expected 110", {load_done, cpu_rst_n, load_err});
        else n_pass++;
    endtask

    task automatic test_bad_checksum();
        int base;
        logic [7:0] bad [] = '{8'hA5, 8'h02, 8'h93, 8'h02, 8'h00, 8'h00,
                               8'h13, 8'h03, 8'h00, 8'h00, 8'h80};
        logic [7:0] good [] = '{8'hA5, 8'h02, 8'h93, 8'h02, 8'h00, 8'h00,
                                8'h13, 8'h03, 8'h00, 8'h00, 8'h81};
        base = wr_cnt;
        send_frame(bad, 11);
        n_checks++;
        if (wr_cnt - base !== 2) $display("FAIL badchk_writes: got %0d expected 2", wr_cnt - base);
        else n_pass++;
        n_checks++;
        if ({load_err, cpu_rst_n, load_done} !== 3'b100)
            $display("FAIL badchk_status: err/cpu/done %b expected 100", {load_err, cpu_rst_n, load_done});
        else n_pass++;
        send_frame(good, 11);
        n_checks++;
        if ({load_err, load_done, cpu_rst_n} !== 3'b011)
            $display("FAIL recover_status: err/done/cpu %b expected 011", {load_err, load_done, cpu_rst_n});
        else n_pass++;
    endtask

    task automatic test_length_garbage();
        int base;
        logic [7:0] empty [] = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00};
        base = wr_cnt;
        send_frame(empty, 6);
        n_checks++;
        if ({load_done, load_err, cpu_rst_n} !== 3'b101 || wr_cnt !== base)
            $display("FAIL empty_frame: done/err/cpu %b writes %0d expected 101 0",
                     {load_done, load_err, cpu_rst_n}, wr_cnt - base);
        else n_pass++;
        send_byte(8'hA5); send_byte(8'h41); idle();
        n_checks++;
        if ({load_err, load_done, cpu_rst_n} !== 3'b100 || wr_cnt !== base)
            $display("FAIL too_long: err/done/cpu %b writes %0d expected 100 0",
                     {load_err, load_done, cpu_rst_n}, wr_cnt - base);
        else n_pass++;
        send_byte(8'hA5); send_byte(8'h40); idle();
        n_checks++;
        if ({load_err, load_done} !== 2'b00)
            $display("FAIL max_len_accepted: err/done %b expected 00", {load_err, load_done});
        else n_pass++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_timeout();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h93); idle();
        repeat (15) @(negedge clk);
        n_checks++;
        if (load_err !== 1'b0) $display("FAIL timeout_early: err %b after 15 cycles expected 0", load_err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({load_err, cpu_rst_n} !== 2'b10)
            $display("FAIL timeout_16: err/cpu %b after 16 cycles expected 10", {load_err, cpu_rst_n});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        logic [7:0] good [] = '{8'hA5, 8'h02, 8'h93, 8'h02, 8'h00, 8'h00,
                                8'h13, 8'h03, 8'h00, 8'h00, 8'h81};
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h93); idle();
        base = wr_cnt;
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rx_ready, mem_we, cpu_rst_n, load_done, load_err} !== 5'b00000 ||
            mem_addr !== '0 || mem_wdata !== 32'h0)
            $display("FAIL async_reset: flags %b addr %0d data %08h expected 00000/0/0",
                     {rx_ready, mem_we, cpu_rst_n, load_done, load_err}, mem_addr, mem_wdata);
        else n_pass++;
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wr_cnt !== base || cpu_rst_n !== 1'b0)
            $display("FAIL reset_no_write: writes %0d cpu %b expected 0 0", wr_cnt - base, cpu_rst_n);
        else n_pass++;
        send_frame(good, 11);
        n_checks++;
        if ({load_done, cpu_rst_n} !== 2'b11 || wr_cnt - base !== 2)
            $display("FAIL post_reset_load: done/cpu %b writes %0d expected 11 2",
                     {load_done, cpu_rst_n}, wr_cnt - base);
        else n_pass++;
    endtask

    task automatic test_reload();
        int base;
        base = wr_cnt;
        send_byte(8'hA5);
        n_checks++;
        if ({cpu_rst_n, load_done} !== 2'b00)
            $display("FAIL reload_drop: cpu/done %b expected 00", {cpu_rst_n, load_done});
        else n_pass++;
        send_byte(8'h01); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h08); idle();
        n_checks++;
        if (wr_cnt - base !== 1 || wr_addr[base % 32] !== 6'd0 || wr_data[base % 32] !== 32'h1234_5678)
            $display("FAIL reload_write: count %0d addr %0d data %08h expected 1 0 12345678",
                     wr_cnt - base, wr_addr[base % 32], wr_data[base % 32]);
        else n_pass++;
        n_checks++;
        if ({load_done, cpu_rst_n, load_err} !== 3'b110)
            $display("FAIL reload_status: done/cpu/err %b expected 110", {load_done, cpu_rst_n, load_err});
        else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_valid_load();
        test_bad_checksum();
        test_length_garbage();
        test_timeout();
        test_reset_mid();
        test_reload();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
